// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
//   Tracks a square sprite in absolute pixel coordinates and renders it,
//   together with an 8-pixel grid, as 3-bit RGB.
//   The ball has two modes, selected once per frame:
//     mode=0 (manual) : the joystick moves the ball, clamped to the screen.
//     mode=1 (bounce) : the ball moves by itself and reflects off all edges.
//   Ports:
//     clk, reset            pixel clock, synchronous active-high reset
//     vsync, display_on     from the VGA timing generator
//     mode                  0 = manual, 1 = bounce
//     up/down/left/right    joystick buttons
//     hpos, vpos            beam position
//     ball_x, ball_y        current top-left corner of the ball
//     hit_h, hit_v          one-cycle edge-hit pulses, left/right and top/bottom
//     rgb                   {b,g,r}, registered, one clock behind hpos/vpos
module ball_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 8,
  parameter int SPEED     = 2,
  parameter int COORD_W   = 10,
  parameter int START_X   = 320,
  parameter int START_Y   = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               display_on,
  input  logic               mode,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               hit_h,
  output logic               hit_v,
  output logic [2:0]         rgb
);

  // Two spare bits: one for the sign, one so that pos+SPEED cannot overflow.
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] XMAX = SW'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [SW-1:0] YMAX = SW'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [SW-1:0] SPD  = SW'(SPEED);
  localparam logic signed [SW-1:0] ZERO = '0;
  localparam logic [COORD_W:0]     BSZ  = (COORD_W+1)'(BALL_SIZE);

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               neg;  // velocity direction: 1 = -SPEED, 0 = +SPEED
    logic               hit;
  } axis_res_t;

  // One axis of the per-frame update. dec/inc are the joystick buttons
  // that move toward 0 / toward the maximum.
  function automatic axis_res_t step_axis(
    input logic [COORD_W-1:0]  pos,
    input logic                neg,
    input logic                bounce,
    input logic                dec,
    input logic                inc,
    input logic signed [SW-1:0] maxv
  );
    axis_res_t r;
    logic signed [SW-1:0] d;
    logic signed [SW-1:0] n;
    r.pos = pos;
    r.neg = neg;
    r.hit = 1'b0;
    if (bounce)            d = neg ? -SPD : SPD;
    else if (dec && !inc)  d = -SPD;
    else if (inc && !dec)  d = SPD;
    else                   d = ZERO;
    n = $signed({2'b00, pos}) + d;
    if (bounce) begin
      if (n <= ZERO) begin
        r.pos = '0;
        r.neg = 1'b0;
        r.hit = 1'b1;
      end else if (n >= maxv) begin
        r.pos = maxv[COORD_W-1:0];
        r.neg = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = n[COORD_W-1:0];
      end
    end else begin
      if (n < ZERO) begin
        r.pos = '0;
        r.hit = 1'b1;
      end else if (n > maxv) begin
        r.pos = maxv[COORD_W-1:0];
        r.hit = 1'b1;
      end else begin
        r.pos = n[COORD_W-1:0];
        // Landing exactly on an edge while pushing still counts as a hit.
        r.hit = (d != ZERO) && ((n == ZERO) || (n == maxv));
      end
    end
    return r;
  endfunction

  logic               r_vsync_q, tick_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic               vx_neg_q, vy_neg_q;
  logic               hit_h_q, hit_v_q;
  logic [2:0]         rgb_q, rgb_d;
  axis_res_t          x_d, y_d;
  logic [COORD_W-1:0] hdiff, vdiff;
  logic               ball_pix, grid;

  always_comb begin
    x_d = step_axis(x_q, vx_neg_q, mode, left, right, XMAX);
    y_d = step_axis(y_q, vy_neg_q, mode, up, down, YMAX);
  end

  // Wrap-around subtraction: a beam left of / above the ball gives a huge
  // difference and so falls outside the sprite without a second compare.
  always_comb begin
    hdiff    = hpos - x_q;
    vdiff    = vpos - y_q;
    ball_pix = ({1'b0, hdiff} < BSZ) && ({1'b0, vdiff} < BSZ);
    grid     = (hpos[2:0] == 3'd0) && (vpos[2:0] == 3'd0);
    rgb_d    = 3'b000;
    if (display_on) begin
      if (ball_pix)  rgb_d = 3'b111;
      else if (grid) rgb_d = 3'b010;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // vsync history starts high so a vsync held through reset is not a rise.
      r_vsync_q <= 1'b1;
      tick_q    <= 1'b0;
      x_q       <= COORD_W'(START_X);
      y_q       <= COORD_W'(START_Y);
      vx_neg_q  <= 1'b0;
      vy_neg_q  <= 1'b0;
      hit_h_q   <= 1'b0;
      hit_v_q   <= 1'b0;
      rgb_q     <= 3'b000;
    end else begin
      r_vsync_q <= vsync;
      tick_q    <= !r_vsync_q && vsync;
      hit_h_q   <= 1'b0;
      hit_v_q   <= 1'b0;
      if (tick_q) begin
        x_q      <= x_d.pos;
        y_q      <= y_d.pos;
        vx_neg_q <= x_d.neg;
        vy_neg_q <= y_d.neg;
        hit_h_q  <= x_d.hit;
        hit_v_q  <= y_d.hit;
      end
      rgb_q <= rgb_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign hit_h  = hit_h_q;
  assign hit_v  = hit_v_q;
  assign rgb    = rgb_q;

endmodule
